// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential 32-bit divider among N_REQ requesters.
// Optional DIV_ZERO_TRAP_EN: a zero divisor is answered directly, skipping the divider.
module div_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  a_in,
  input  logic [32*N_REQ-1:0]  b_in,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          q_out,
  output logic [31:0]          r_out,
  output logic                 dz_err,
  output logic                 busy,
  output logic                 div_start,
  output logic [31:0]          div_a,
  output logic [31:0]          div_b,
  input  logic [31:0]          div_d,
  input  logic [31:0]          div_r,
  input  logic                 div_done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [N_REQ-1:0] gnt_nxt, rsp_nxt;
  logic [31:0]      q_nxt, r_nxt, a_nxt, b_nxt;
  logic             dz_nxt, start_nxt;

  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] lo_idx, hi_idx, win_idx;
  logic             lo_found, hi_found;
  logic [N_REQ-1:0] win_onehot;
  logic [31:0]      win_a, win_b;
  logic             try_grant;

  // The owner still holds req while its response is pulsed in RESP, so it is
  // masked there; other pending requesters are granted straight from RESP.
  always_comb begin
    cand     = (state == RESP) ? (req & ~gnt) : req;
    lo_idx   = '0;
    hi_idx   = '0;
    lo_found = 1'b0;
    hi_found = 1'b0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      if (cand[k-1]) begin
        lo_idx   = IDX_W'(k-1);
        lo_found = 1'b1;
        if ((k-1) >= 32'(ptr)) begin
          hi_idx   = IDX_W'(k-1);
          hi_found = 1'b1;
        end
      end
    end
    win_idx             = hi_found ? hi_idx : lo_idx;
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
    win_a               = a_in[32*win_idx +: 32];
    win_b               = b_in[32*win_idx +: 32];
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    rsp_nxt   = '0;
    q_nxt     = q_out;
    r_nxt     = r_out;
    dz_nxt    = dz_err;
    start_nxt = div_start;
    a_nxt     = div_a;
    b_nxt     = div_b;
    try_grant = 1'b0;

    case (state)
      IDLE:   try_grant = 1'b1;
      LAUNCH: if (!div_done) state_nxt = RUN;
      RUN: begin
        if (div_done) begin
          q_nxt     = div_d;
          r_nxt     = div_r;
          dz_nxt    = 1'b0;
          rsp_nxt   = gnt;
          start_nxt = 1'b0;
          state_nxt = RESP;
        end
      end
      RESP: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
        try_grant = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    if (try_grant && lo_found) begin
      gnt_nxt = win_onehot;
      a_nxt   = win_a;
      b_nxt   = win_b;
      ptr_nxt = (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
`ifdef DIV_ZERO_TRAP_EN
      if (win_b == '0) begin
        start_nxt = 1'b0;
        q_nxt     = '1;
        r_nxt     = win_a;
        dz_nxt    = 1'b1;
        rsp_nxt   = win_onehot;
        state_nxt = RESP;
      end else begin
        start_nxt = 1'b1;
        state_nxt = LAUNCH;
      end
`else
      start_nxt = 1'b1;
      state_nxt = LAUNCH;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      q_out     <= '0;
      r_out     <= '0;
      dz_err    <= 1'b0;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      rsp_valid <= rsp_nxt;
      q_out     <= q_nxt;
      r_out     <= r_nxt;
      dz_err    <= dz_nxt;
      div_start <= start_nxt;
      div_a     <= a_nxt;
      div_b     <= b_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule
